// File: rtl/neuron4_input_loader.sv
// Groups a valid/ready sample stream into 4-lane frames for the neuron4 stage.
// A shadow frame fills while the held lanes are presented, then waits SETTLE cycles.
module neuron4_input_loader #(
  parameter int unsigned IW     = 16,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CW     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [IW-1:0] s_data,
  input  logic                 s_last,
  output logic signed [IW-1:0] in0,
  output logic signed [IW-1:0] in1,
  output logic signed [IW-1:0] in2,
  output logic signed [IW-1:0] in3,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 err_framing,
  output logic [CW-1:0]        frame_count
);

  localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSettle, StPresent} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]       shadow_q [4];
  logic [IW-1:0]       shadow_d [4];
  logic [IW-1:0]       lane_q [4];
  logic [IW-1:0]       lane_d [4];
  logic [1:0]          idx_q, idx_d;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  logic                load;
  logic                fire;
  logic                accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; load moves the shadow frame into the lanes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (full_q) begin
          load = 1'b1;
          if (SETTLE > 0) begin
            state_d = StSettle;
            cnt_d   = CntW'(SETTLE);
          end else begin
            state_d = StPresent;
          end
        end
      end
      StSettle: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StPresent;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPresent: begin
        if (frame_ready) begin
          fire = 1'b1;
          if (full_q) begin
            load = 1'b1;
            if (SETTLE > 0) begin
              state_d = StSettle;
              cnt_d   = CntW'(SETTLE);
            end else begin
              state_d = StPresent;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    frame_valid = (state_q == StPresent);
  end

  assign s_ready = !full_q;
  assign accept  = s_valid && !full_q;

  // Fill side; load and accept are mutually exclusive since both depend on full_q
  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    full_d   = full_q;
    err_d    = 1'b0;
    if (load) begin
      full_d = 1'b0;
    end
    if (accept) begin
      shadow_d[idx_q] = s_data;
      if (idx_q == 2'd3) begin
        full_d = 1'b1;
        idx_d  = 2'd0;
        err_d  = !s_last;
      end else if (s_last) begin
        idx_d = 2'd0;
        err_d = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_comb begin
    lane_d = lane_q;
    if (load) begin
      lane_d = shadow_q;
    end
    fcnt_d = fire ? fcnt_q + 1'b1 : fcnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '{default: '0};
      lane_q   <= '{default: '0};
      idx_q    <= 2'd0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      lane_q   <= lane_d;
      idx_q    <= idx_d;
      full_q   <= full_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign in0         = lane_q[0];
  assign in1         = lane_q[1];
  assign in2         = lane_q[2];
  assign in3         = lane_q[3];
  assign err_framing = err_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_neuron4_input_loader.sv
// Bench for neuron4_input_loader: three instances (SETTLE=1, SETTLE=0/CW=4, SETTLE=4)
// checked against a frame-level queue model of the sample stream.
module tb_neuron4_input_loader;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          sel = 2'd0;
  logic                sv = 1'b0, sl = 1'b0, fr = 1'b0;
  logic signed [IW-1:0] sd = '0;
  logic [2:0]          v_i, r_i, sready, fvalid, errf;
  logic [2:0][IW-1:0]  l0, l1, l2, l3;
  logic [15:0]         cnt_a, cnt_c;
  logic [3:0]          cnt_b;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      v_i[k] = sv && (sel == 2'(k));
      r_i[k] = fr && (sel == 2'(k));
    end
  end

  neuron4_input_loader #(.IW(IW), .SETTLE(1), .CW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(v_i[0]), .s_ready(sready[0]), .s_data(sd),
    .s_last(sl), .in0(l0[0]), .in1(l1[0]), .in2(l2[0]), .in3(l3[0]),
    .frame_valid(fvalid[0]), .frame_ready(r_i[0]), .err_framing(errf[0]),
    .frame_count(cnt_a));
  neuron4_input_loader #(.IW(IW), .SETTLE(0), .CW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(v_i[1]), .s_ready(sready[1]), .s_data(sd),
    .s_last(sl), .in0(l0[1]), .in1(l1[1]), .in2(l2[1]), .in3(l3[1]),
    .frame_valid(fvalid[1]), .frame_ready(r_i[1]), .err_framing(errf[1]),
    .frame_count(cnt_b));
  neuron4_input_loader #(.IW(IW), .SETTLE(4), .CW(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .s_valid(v_i[2]), .s_ready(sready[2]), .s_data(sd),
    .s_last(sl), .in0(l0[2]), .in1(l1[2]), .in2(l2[2]), .in3(l3[2]),
    .frame_valid(fvalid[2]), .frame_ready(r_i[2]), .err_framing(errf[2]),
    .frame_count(cnt_c));

  logic             o_rdy, o_fv, o_err;
  logic [4*IW-1:0]  o_lanes;
  logic [15:0]      o_cnt;
  always_comb begin
    o_rdy   = sready[sel];
    o_fv    = fvalid[sel];
    o_err   = errf[sel];
    o_lanes = {l0[sel], l1[sel], l2[sel], l3[sel]};
    o_cnt   = (sel == 2'd0) ? cnt_a : (sel == 2'd1) ? {12'd0, cnt_b} : cnt_c;
  end

  // Frame-level model: accepted samples grouped by the s_last rules into expected frames
  logic [4*IW-1:0] exp_q [$];
  logic [IW-1:0]   part [$];
  int err_exp = 0, err_obs = 0, fire_bad = 0, stable_viol = 0, cyc = 0;
  int fires [3];
  logic last_acc = 1'b0, last_fire = 1'b0, last_fv = 1'b0, prev_hold = 1'b0;
  logic [4*IW-1:0] last_fire_lanes = '0, prev_lanes = '0;
  int total = 0, bad = 0;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (prev_hold && o_lanes !== prev_lanes) stable_viol++;
    if (o_err === 1'b1) err_obs++;
    last_acc  = sv && o_rdy && rst_n;
    last_fv   = o_fv;
    last_fire = o_fv && fr;
    if (last_acc) begin
      part.push_back(sd);
      if (part.size() == 4) begin
        if (!sl) err_exp++;
        exp_q.push_back({part[0], part[1], part[2], part[3]});
        part.delete();
      end else if (sl) begin
        err_exp++;
        part.delete();
      end
    end
    if (last_fire) begin
      fires[sel]++;
      last_fire_lanes = o_lanes;
      if (exp_q.size() == 0 || o_lanes !== exp_q[0]) fire_bad++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    prev_hold  = o_fv && !fr;
    prev_lanes = o_lanes;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] d, input logic last, output logic ok);
    sv = 1'b1; sd = d; sl = last; ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (last_acc) begin
        ok = 1'b1;
        break;
      end
    end
    sv = 1'b0; sl = 1'b0;
  endtask

  task automatic wait_fire(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (last_fire) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic select(input logic [1:0] k);
    sel = k; part.delete(); exp_q.delete(); prev_hold = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sv = 1'b1; sd = 16'h1234; sl = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_fv !== 1'b0 || o_err !== 1'b0 || o_lanes !== '0 || o_cnt !== 16'd0 || o_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold: fv=%b err=%b lanes=%h cnt=%0d rdy=%b, required 0 0 0 0 1",
               o_fv, o_err, o_lanes, o_cnt, o_rdy);
    end
    sv = 1'b0; sl = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    total++;
    if (o_fv !== 1'b0 || err_obs !== 0 || o_lanes !== '0 || o_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: fv=%b errs=%0d lanes=%h rdy=%b, required 0 0 0 1",
               o_fv, err_obs, o_lanes, o_rdy);
    end
  endtask

  task automatic test_basic();
    logic signed [IW-1:0] smp [4];
    logic [4*IW-1:0] expf;
    logic ok, allok;
    int k, first, nfv;
    smp = '{16'sd384, -16'sd51, -16'sd77, -16'sd26};
    expf = {smp[0], smp[1], smp[2], smp[3]};
    fr = 1'b1; allok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(smp[i], i == 3, ok);
      allok &= ok;
    end
    k = cyc; first = -1; nfv = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (last_fv) begin
        nfv++;
        if (first < 0) first = cyc;
      end
    end
    fr = 1'b0;
    total++;
    if (!allok) begin
      bad++; $display("FAIL basic_accept: samples not accepted within bound");
    end
    total++;
    if (first - k != 3) begin
      bad++; $display("FAIL basic_latency: valid at +%0d cycles, required +3", first - k);
    end
    total++;
    if (nfv != 1) begin
      bad++; $display("FAIL basic_valid_len: %0d cycles, required 1", nfv);
    end
    total++;
    if (last_fire_lanes !== expf) begin
      bad++; $display("FAIL basic_lanes: got %h required %h", last_fire_lanes, expf);
    end
    total++;
    if (o_cnt !== 16'd1) begin
      bad++; $display("FAIL basic_count: got %0d required 1", o_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] f1 [4], f2 [4];
    logic [4*IW-1:0] e1, e2;
    logic ok, allok;
    int base;
    for (int i = 0; i < 4; i++) begin
      f1[i] = 16'($urandom);
      f2[i] = 16'($urandom);
    end
    e1 = {f1[0], f1[1], f1[2], f1[3]};
    e2 = {f2[0], f2[1], f2[2], f2[3]};
    base = fires[0];
    fr = 1'b0; allok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(f1[i], i == 3, ok); allok &= ok;
    end
    for (int i = 0; i < 4; i++) begin
      send(f2[i], i == 3, ok); allok &= ok;
    end
    total++;
    if (!allok || o_rdy !== 1'b0) begin
      bad++; $display("FAIL b2b_ready_low: ok=%b rdy=%b, required 1 0", allok, o_rdy);
    end
    repeat (10) step();
    total++;
    if (o_lanes !== e1 || o_fv !== 1'b1 || o_rdy !== 1'b0 || stable_viol != 0) begin
      bad++;
      $display("FAIL b2b_hold: lanes=%h fv=%b rdy=%b viol=%0d, required %h 1 0 0",
               o_lanes, o_fv, o_rdy, stable_viol, e1);
    end
    fr = 1'b1;
    step();
    fr = 1'b0;
    total++;
    if (o_lanes !== e2 || o_cnt !== 16'(base + 1)) begin
      bad++;
      $display("FAIL b2b_switch: lanes=%h cnt=%0d, required %h %0d", o_lanes, o_cnt, e2, base + 1);
    end
    fr = 1'b1;
    wait_fire(20, ok);
    fr = 1'b0;
    total++;
    if (!ok || o_cnt !== 16'(base + 2) || fire_bad != 0) begin
      bad++;
      $display("FAIL b2b_second: fired=%b cnt=%0d badfires=%0d, required 1 %0d 0",
               ok, o_cnt, fire_bad, base + 2);
    end
  endtask

  task automatic test_framing_short();
    logic [IW-1:0] c [4];
    logic [4*IW-1:0] ec;
    logic ok;
    int e0, f0;
    e0 = err_obs; f0 = fires[0];
    fr = 1'b1;
    send(16'h0aaa, 1'b0, ok);
    send(16'h0bbb, 1'b1, ok);
    for (int i = 0; i < 4; i++) c[i] = 16'($urandom);
    ec = {c[0], c[1], c[2], c[3]};
    for (int i = 0; i < 4; i++) send(c[i], i == 3, ok);
    wait_fire(20, ok);
    repeat (3) step();
    fr = 1'b0;
    total++;
    if (err_obs - e0 != 1) begin
      bad++; $display("FAIL short_err: pulses=%0d required 1", err_obs - e0);
    end
    total++;
    if (!ok || fires[0] - f0 != 1 || last_fire_lanes !== ec) begin
      bad++;
      $display("FAIL short_frame: fires=%0d lanes=%h, required 1 %h",
               fires[0] - f0, last_fire_lanes, ec);
    end
  endtask

  task automatic test_no_last();
    logic [IW-1:0] d [4];
    logic [4*IW-1:0] ed;
    logic ok;
    int e0;
    e0 = err_obs;
    fr = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
    ed = {d[0], d[1], d[2], d[3]};
    for (int i = 0; i < 4; i++) send(d[i], 1'b0, ok);
    wait_fire(20, ok);
    repeat (2) step();
    fr = 1'b0;
    total++;
    if (err_obs - e0 != 1) begin
      bad++; $display("FAIL nolast_err: pulses=%0d required 1", err_obs - e0);
    end
    total++;
    if (!ok || last_fire_lanes !== ed) begin
      bad++; $display("FAIL nolast_frame: fired=%b lanes=%h required %h", ok, last_fire_lanes, ed);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sv = ($urandom_range(0, 3) != 0);
      sd = 16'($urandom);
      sl = (part.size() == 3);
      if ($urandom_range(0, 15) == 0) sl = ~sl;
      fr = ($urandom_range(0, 2) != 0);
      step();
    end
    sv = 1'b0; sl = 1'b0; fr = 1'b1;
    repeat (20) step();
    fr = 1'b0;
    total++;
    if (fire_bad != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_frames: wrong=%0d pending=%0d required 0 0", fire_bad, exp_q.size());
    end
    total++;
    if (err_obs != err_exp) begin
      bad++; $display("FAIL random_err: pulses=%0d required %0d", err_obs, err_exp);
    end
    total++;
    if (stable_viol != 0) begin
      bad++; $display("FAIL random_stable: lane changes while held=%0d required 0", stable_viol);
    end
    total++;
    if (o_cnt !== 16'(fires[0])) begin
      bad++; $display("FAIL random_count: got %0d required %0d", o_cnt, 16'(fires[0]));
    end
  endtask

  task automatic test_wrap();
    logic [4*IW-1:0] e1;
    logic [IW-1:0] d [4];
    logic ok;
    int k, first;
    select(2'd1);
    fr = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 16'($urandom);
    e1 = {d[0], d[1], d[2], d[3]};
    for (int i = 0; i < 4; i++) send(d[i], i == 3, ok);
    k = cyc; first = -1;
    for (int j = 0; j < 6; j++) begin
      step();
      if (last_fv && first < 0) first = cyc;
    end
    total++;
    if (first - k != 2 || last_fire_lanes !== e1) begin
      bad++;
      $display("FAIL s0_latency: valid at +%0d lanes=%h, required +2 %h", first - k, last_fire_lanes, e1);
    end
    for (int f = 1; f < 16; f++) begin
      for (int i = 0; i < 4; i++) send(16'($urandom), i == 3, ok);
    end
    repeat (4) step();
    total++;
    if (o_cnt !== 16'd0 || fires[1] != 16 || fire_bad != 0) begin
      bad++;
      $display("FAIL s0_wrap: cnt=%0d fires=%0d wrong=%0d, required 0 16 0", o_cnt, fires[1], fire_bad);
    end
    for (int i = 0; i < 4; i++) send(16'($urandom), i == 3, ok);
    repeat (4) step();
    fr = 1'b0;
    total++;
    if (o_cnt !== 16'd1) begin
      bad++; $display("FAIL s0_after_wrap: cnt=%0d required 1", o_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [IW-1:0] a [4], n [4];
    logic [4*IW-1:0] ea, en;
    logic ok;
    select(2'd2);
    fr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a[i] = 16'($urandom);
      n[i] = 16'($urandom);
    end
    ea = {a[0], a[1], a[2], a[3]};
    en = {n[0], n[1], n[2], n[3]};
    for (int i = 0; i < 4; i++) send(a[i], i == 3, ok);
    send(16'h1111, 1'b0, ok);
    send(16'h2222, 1'b0, ok);
    total++;
    if (o_lanes !== ea || o_fv !== 1'b0 || fires[2] != 0) begin
      bad++;
      $display("FAIL mid_settle: lanes=%h fv=%b fires=%0d, required %h 0 0", o_lanes, o_fv, fires[2], ea);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (o_lanes !== '0 || o_fv !== 1'b0 || o_cnt !== 16'd0 || o_rdy !== 1'b1 || o_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: lanes=%h fv=%b cnt=%0d rdy=%b err=%b, required 0 0 0 1 0",
               o_lanes, o_fv, o_cnt, o_rdy, o_err);
    end
    part.delete(); exp_q.delete(); prev_hold = 1'b0;
    foreach (fires[i]) fires[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(n[i], i == 3, ok);
    wait_fire(20, ok);
    fr = 1'b0;
    total++;
    if (!ok || last_fire_lanes !== en || o_cnt !== 16'd1) begin
      bad++;
      $display("FAIL mid_after: fired=%b lanes=%h cnt=%0d, required 1 %h 1",
               ok, last_fire_lanes, o_cnt, en);
    end
  endtask

  initial begin
    foreach (fires[i]) fires[i] = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_framing_short();
    test_no_last();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/neuron4_input_loader.md
Name: neuron4_input_loader

Overview:
Upstream feeder for the combinational neuron4 stage. It accepts a valid/ready stream of signed IW-bit samples and groups them, four at a time, into a shadow frame. Each completed frame moves to held output lanes in0..in3, which drive neuron4 directly. The block waits a programmable settle time so the neuron's combinational output is stable, then raises frame_valid and holds the lanes until the consumer handshakes. Double buffering lets the next frame fill while the current one is presented.

Parameters:
IW, 16, sample and lane width (signed); matches neuron4 IW
SETTLE, 1, cycles the lanes are held before frame_valid rises (0 allowed)
CW, 16, width of frame_count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  loader can accept a sample
s_data  in  IW  signed input sample
s_last  in  1  marks the 4th (final) sample of a frame
in0  out  IW  lane 0 to neuron4
in1  out  IW  lane 1 to neuron4
in2  out  IW  lane 2 to neuron4
in3  out  IW  lane 3 to neuron4
frame_valid  out  1  lanes are stable and neuron output is settled
frame_ready  in  1  consumer has captured the neuron output
err_framing  out  1  one-cycle pulse on an s_last framing violation
frame_count  out  CW  frames released by handshake; wraps modulo 2^CW

Behaviour:
- Reset (async assert, sync release): lanes 0, shadow regs 0, idx 0, shadow_full 0, state IDLE, frame_valid 0, err_framing 0, frame_count 0.
- s_ready = !shadow_full (combinational from register). No sample is accepted while rst_n is low.
- Fill side:
  - Accept when s_valid && s_ready. shadow[idx] <= s_data; idx increments, wrapping 3->0.
  - Accept at idx==3 sets shadow_full.
  - s_last on an accept with idx!=3: frame is discarded, idx <= 0, shadow_full is not set, err_framing pulses.
  - Accept at idx==3 without s_last: frame is kept (shadow_full set), err_framing pulses.
- Output FSM, states IDLE / SETTLE / PRESENT:
  - IDLE: if shadow_full, load in0..in3 <= shadow[0..3] and clear shadow_full. If SETTLE>0, go to SETTLE with cnt <= SETTLE; else go to PRESENT.
  - SETTLE: cnt decrements each cycle; move to PRESENT on the edge where cnt==1. Lanes hold in SETTLE for exactly SETTLE cycles.
  - PRESENT: frame_valid=1 and lanes are held. On frame_ready, frame_count increments.
    - If shadow_full in that same cycle: reload lanes from shadow, clear shadow_full, enter SETTLE (or stay in PRESENT if SETTLE==0, so frame_valid stays high back-to-back).
    - Otherwise go to IDLE.
- frame_valid is a registered state decode (high only in PRESENT). frame_ready is ignored outside PRESENT.
- Latency: 4th sample accepted at edge E0 with output idle -> lanes update at E1 -> frame_valid high after edge E1+SETTLE (SETTLE=1: 2 cycles after E0).
- s_ready drops for one cycle after a frame completes. Refill of the next frame may proceed during SETTLE and PRESENT.
- Lanes never change while frame_valid=1 except on the handshake edge.
- Stall: in PRESENT with frame_ready=0 and shadow_full=1, s_ready stays 0 and lanes hold indefinitely.
- Reset mid-operation: partial frames, shadow contents and the presented frame are all dropped; frame_count returns to 0.
- Data passes bit-exact, with no arithmetic on the samples.

Test Plan:
- Samples 384, -51, -77, -26 (s_last on the 4th), frame_ready=1, SETTLE=1 -> in0..in3 = 384/-51/-77/-26; frame_valid high exactly 2 cycles after the 4th accept, for 1 cycle; frame_count=1; neuron4 out (W=307,-896,26,-8) stable while frame_valid=1.
- Two back-to-back frames with frame_ready=0 for 10 cycles -> s_ready low after the 2nd frame fills; lanes hold frame 1; on frame_ready, lanes switch to frame 2 and frame_count=1 then 2.
- s_last on the 2nd sample -> err_framing pulses once; no frame_valid; next 4 samples form a clean frame starting at lane 0.
- 4 samples without s_last -> err_framing pulses once and the frame is still presented normally.
- SETTLE=0, continuous stream, frame_ready=1 -> frame_valid rises the cycle after lane load; frame_count wraps 0xFFFF->0 after 65536 frames (preload by forcing, or use CW=4 to wrap 15->0).
- Assert rst_n=0 during SETTLE with a partial second frame held -> all outputs 0 immediately; after release, the first new 4 samples map to in0..in3 in order.
